// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: one-command-at-a-time valid/ready front-end for the 8x8 single-port SRAM.
// Optional write read-back verify is compiled in with `define SRAM_CTRL_WRVERIFY_EN.
module sram_req_ctrl #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_wr,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [7:0]    err_cnt,
    output logic          sram_cs,
    output logic          sram_re,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd6;
`ifdef SRAM_CTRL_WRVERIFY_EN
    localparam logic [2:0] S_VRD   = 3'd4;
    localparam logic [2:0] S_VCAPT = 3'd5;
`endif

    logic [2:0] state;
    logic       rd_strobe;
    logic       rsp_take;

    // sram_addr / sram_din double as the registered command address and write data.
`ifdef SRAM_CTRL_WRVERIFY_EN
    assign rd_strobe = (state == S_RD) || (state == S_VRD);
`else
    assign rd_strobe = (state == S_RD);
`endif

    assign req_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_RESP) && !rst;
    assign rsp_take  = rsp_valid && rsp_ready;

    // cs stays high through reset so the SRAM clears its array.
    assign sram_cs = rst || (state == S_WR) || rd_strobe;
    assign sram_we = !rst && (state == S_WR);
    assign sram_re = !rst && rd_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sram_addr <= '0;
            sram_din  <= '0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        sram_addr <= req_addr;
                        sram_din  <= req_wdata;
                        rsp_wr    <= req_we;
                        rsp_rdata <= '0;
                        state     <= req_we ? S_WR : S_RD;
                    end
                end
`ifdef SRAM_CTRL_WRVERIFY_EN
                S_WR:    state <= S_VRD;
                S_VRD:   state <= S_VCAPT;
                S_VCAPT: state <= S_RESP;
`else
                S_WR:    state <= S_RESP;
`endif
                S_RD:    state <= S_CAPT;
                S_CAPT: begin
                    rsp_rdata <= sram_dout;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_CTRL_WRVERIFY_EN
    logic       err_q;
    logic [7:0] err_cnt_q;

    assign rsp_err = err_q;
    assign err_cnt = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (req_valid && req_ready)
                err_q <= 1'b0;
            else if (state == S_VCAPT)
                err_q <= (sram_dout != sram_din);
            if (rsp_take && err_q && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`else
    assign rsp_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench for sram_req_ctrl: behavioural SRAM, reference memory model and a decoupled monitor.
module tb_sram_req_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;
`ifdef SRAM_CTRL_WRVERIFY_EN
    localparam bit VERIFY = 1'b1;
    localparam int WR_LAT = 4;
`else
    localparam bit VERIFY = 1'b0;
    localparam int WR_LAT = 2;
`endif
    localparam int RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [7:0]    err_cnt;
    logic          sram_cs, sram_re, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    logic rr_rand = 1'b0;
    logic rr_hold = 1'b1;
    logic rr_bit  = 1'b1;
    assign rsp_ready = rr_rand ? rr_bit : rr_hold;

    sram_req_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
        .sram_cs(sram_cs), .sram_re(sram_re), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rr_bit <= 1'($urandom_range(0, 1));

    // Behavioural SRAM; under verify builds it corrupts bit 0 of any 0x80 write.
    logic [DW-1:0] smem [8];
    always @(posedge clk) begin
        if (sram_cs && rst) begin
            for (int i = 0; i < 8; i++) smem[i] <= '0;
            sram_dout <= '0;
        end else if (sram_cs && sram_we) begin
            smem[sram_addr] <= (VERIFY && sram_din == 8'h80) ? (sram_din ^ 8'h01) : sram_din;
        end else if (sram_cs && sram_re) begin
            sram_dout <= smem[sram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
    } sb_t;

    sb_t           q[$];
    logic [DW-1:0] exp_mem [8];
    int            exp_ec = 0;
    int            hs_cnt = 0;
    logic          prev_v = 1'b0;
    sb_t           mon_e;

    // Monitor: compares the queue head whenever a response is presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (sram_re && sram_we) chk("strobe re&we", 1, 0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected rsp_valid", 1, 0);
                end else begin
                    mon_e = q[0];
                    chk("rsp_wr", rsp_wr, mon_e.wr);
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("rsp_err", rsp_err, mon_e.err);
                    chk("req_ready in resp", req_ready, 0);
                    if (!prev_v) chk("rsp latency cycle", cyc, mon_e.due);
                    if (rsp_ready) begin
                        chk("err_cnt", err_cnt, exp_ec);
                        void'(q.pop_front());
                        hs_cnt++;
                        if (mon_e.err && exp_ec != 255) exp_ec++;
                    end
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        sb_t e;
        logic bad;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (we) begin
            bad        = VERIFY && (d == 8'h80);
            exp_mem[a] = bad ? (d ^ 8'h01) : d;
            e = '{wr: 1'b1, rdata: '0, err: bad, due: cyc + WR_LAT};
        end else begin
            e = '{wr: 1'b0, rdata: exp_mem[a], err: 1'b0, due: cyc + RD_LAT};
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain timeout", 0, 1);
    endtask

    task automatic set_ready(input logic rnd, input logic hold);
        @(posedge clk);
        #1;
        rr_rand = rnd;
        rr_hold = hold;
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        exp_ec = 0;
        repeat (ncyc) begin
            @(negedge clk);
            chk("cs in reset", sram_cs, 1);
            chk("re in reset", sram_re, 0);
            chk("we in reset", sram_we, 0);
            chk("req_ready in reset", req_ready, 0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hs0;
        logic [DW-1:0] rd;
        do_reset(2);
        @(negedge clk);
        chk("rst req_ready", req_ready, 1);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_wr", rsp_wr, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("rst sram_addr", sram_addr, 0);
        chk("rst sram_din", sram_din, 0);
        chk("rst sram_cs", sram_cs, 0);

        // Reset clears the array: write A5, reset, read back zero.
        issue(1'b1, 3'd3, 8'hA5);
        drain();
        do_reset(2);
        issue(1'b0, 3'd3, 8'h00);
        drain();

        // Write then read the same address.
        issue(1'b1, 3'd7, 8'h5C);
        issue(1'b0, 3'd7, 8'h00);
        drain();

        // Sweep all addresses.
        for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), DW'(8'h10 + i));
        for (int i = 0; i < 8; i++) issue(1'b0, AW'(i), 8'h00);
        drain();

        // Backpressure on a read of addr 2.
        issue(1'b1, 3'd2, 8'h3E);
        drain();
        set_ready(1'b0, 1'b0);
        issue(1'b0, 3'd2, 8'h00);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        hs0 = hs_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("stall rsp_valid", rsp_valid, 1);
            chk("stall req_ready", req_ready, 0);
            chk("stall rsp_rdata", rsp_rdata, 8'h3E);
        end
        set_ready(1'b0, 1'b1);
        drain();
        chk("stall handshakes", hs_cnt, hs0 + 1);

        // Reset while the read sits in the capture cycle.
        issue(1'b1, 3'd4, 8'h77);
        drain();
        issue(1'b0, 3'd4, 8'h00);
        do_reset(1);
        @(negedge clk);
        chk("post-abort req_ready", req_ready, 1);
        chk("post-abort rsp_valid", rsp_valid, 0);
        repeat (4) @(negedge clk);

        // Write-verify mismatch (only flagged in verify builds).
        issue(1'b1, 3'd1, 8'h80);
        drain();
        @(negedge clk);
        chk("err_cnt after 0x80", err_cnt, VERIFY ? 1 : 0);
        issue(1'b0, 3'd1, 8'h00);
        drain();

        // Randomised traffic with random response backpressure.
        set_ready(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            rd = ($urandom_range(0, 7) == 0) ? 8'h80 : DW'($urandom);
            issue(1'($urandom_range(0, 1)), AW'($urandom), rd);
        end
        set_ready(1'b0, 1'b1);
        drain();
        @(negedge clk);
        chk("final err_cnt", err_cnt, exp_ec);

        $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request/response front-end for the 8x8 single-port SRAM. Accepts one read or write command at a time on a valid/ready interface and sequences the SRAM's `cs`/`re`/`we`/`addr`/`data_in` strobes. It captures the SRAM's registered `data_out` and returns every command's result on a valid/ready response channel. It sits directly upstream of the SRAM and is the only master driving its pins.

## Interface
Parameters:
- AW, 3, address width (SRAM depth 2^AW = 8)
- DW, 8, data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high; also forwarded to the SRAM
- req_valid  in  1  command present
- req_ready  out  1  controller accepts a command this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  command address
- req_wdata  in  DW  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_wr  out  1  response belongs to a write
- rsp_rdata  out  DW  read data; 0 for writes
- rsp_err  out  1  write-verify mismatch; 0 when the feature is compiled out
- err_cnt  out  8  saturating count of rsp_err responses
- sram_cs, sram_re, sram_we  out  1 each  SRAM strobes
- sram_addr  out  AW  SRAM address
- sram_din  out  DW  SRAM write data
- sram_dout  in  DW  SRAM registered read data

## Operation
- States:
  - IDLE
  - WR: strobe, 1 cycle
  - RD: strobe, 1 cycle
  - CAPT: sample sram_dout, 1 cycle
  - VRD, VCAPT: verify only
  - RESP: hold response
- `req_ready = (state==IDLE) && !rst`.
- Accept on `req_valid && req_ready`. At acceptance, register `req_we`, `req_addr` and `req_wdata`. The next state is WR if the command is a write, otherwise RD.
- WR drives `sram_cs=1`, `sram_we=1`, `sram_re=0`, the registered address and the registered data. It then goes to RESP, or to VRD when verify is enabled.
- RD drives `sram_cs=1`, `sram_re=1`, `sram_we=0`, then goes to CAPT.
- In CAPT, `rsp_rdata <= sram_dout`, then go to RESP.
- In RESP, `rsp_valid=1`. Response fields stay stable until `rsp_ready`. On `rsp_ready`, go to IDLE.
- `sram_re` and `sram_we` are never high together. Outside WR/RD/VRD both are 0.
- `err_cnt` increments on each handshake of a response with `rsp_err=1`. It saturates at 255.
- Reset:
  - While `rst`=1, drive `sram_cs=1`, `sram_re=0`, `sram_we=0`. The SRAM clears its contents only when `cs` is high during reset.
  - After reset: state IDLE; `rsp_valid`, `rsp_wr`, `rsp_err` = 0; `rsp_rdata` = 0; `err_cnt` = 0; `sram_addr` = 0; `sram_din` = 0.
  - Reset mid-command aborts the command. No response is produced.
- There is no command queue. `req_*` inputs are ignored outside IDLE.

## Timing
- Write accepted at edge N:
  - WR is the cycle after edge N; the SRAM writes at edge N+1.
  - `rsp_valid` is high from edge N+2.
- Read accepted at edge N:
  - RD strobe in the cycle after edge N.
  - `sram_dout` is valid after edge N+1.
  - Captured at edge N+2.
  - `rsp_valid` is high from edge N+3.
- Back-to-back throughput, with `rsp_ready` held high:
  - A write takes 3 cycles per command: WR, RESP, IDLE.
  - A read takes 4 cycles per command: RD, CAPT, RESP, IDLE.
- A read at the same address immediately after a write returns the new data, because the write completes before the read is accepted.
- `rsp_ready` held low stalls in RESP indefinitely. Nothing is dropped.

## Configuration
- Macro: `SRAM_CTRL_WRVERIFY_EN`.
- When defined, every write is followed by a read-back:
  - WR goes to VRD, which strobes `re` at the same address.
  - VRD goes to VCAPT, which compares `sram_dout` to the registered wdata.
  - VCAPT goes to RESP.
  - On mismatch, `rsp_err=1`.
  - `rsp_rdata` is still 0 for writes.
  - Write response latency becomes edge N+4.
- When undefined:
  - VRD and VCAPT do not exist.
  - `rsp_err` is constant 0.
  - `err_cnt` stays 0.

## Test plan
- Reset: hold `rst` 2 cycles after writing 0xA5 to addr 3, then read addr 3 → `sram_cs=1` during reset, `rsp_rdata=0x00`, `rsp_wr=0`.
- Write then read: write 0x5C to addr 7, then read addr 7 → write `rsp_valid` at edge N+2 with `rsp_wr=1`; read `rsp_valid` at edge N+3 with `rsp_rdata=0x5C`.
- Sweep: write 0x10+i to addr i for i=0..7, then read all, with `rsp_ready` held high → data matches, and the strobe check never sees `re` and `we` high together.
- Backpressure: issue a read of addr 2 (holding 0x3E) with `rsp_ready=0` for 5 cycles → `rsp_valid` and `rsp_rdata=0x3E` are stable, `req_ready=0` throughout, and one handshake occurs when `rsp_ready` rises.
- Reset mid-read: assert `rst` during CAPT → no `rsp_valid`, state IDLE, `req_ready=1` the cycle after `rst` drops.
- With the macro defined, a bench SRAM model corrupts write data bit 0 for a write of 0x80 → `rsp_err=1`, `err_cnt=1`, write response at edge N+4.
